// File: rtl/sen_det_pkg.sv
// Shared types and constants for the side-street sensor path.
// Light encodings are common with ej_maq_est.
package sen_det_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL_ON  = 2'd1,
        PRESENT  = 2'd2,
        QUAL_OFF = 2'd3
    } state_t;

    // Side-street light encoding: [2]=red [1]=yellow [0]=green
    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    // Width of a counter that must reach n-1; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/loop_debounce.sv
// Loop input conditioning: 2-flop synchronizer followed by a debounce FSM.
// veh_pulse marks the cycle a rising level is accepted; loop_db is the
// debounced loop level.
module loop_debounce
    import sen_det_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
)(
    input  logic   clk,
    input  logic   rst,
    input  logic   loop_raw,
    output logic   loop_db,
    output logic   veh_pulse,
    output state_t state
);

    localparam int unsigned     DW       = cnt_width(DEB_CYCLES);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync_1;
    logic          loop_s;
    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_next;
    state_t        state_next;
    logic          cnt_done;

    // Bring the asynchronous loop pin into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            loop_s <= 1'b0;
        end else begin
            sync_1 <= loop_raw;
            loop_s <= sync_1;
        end
    end

    assign cnt_done = (cnt == DEB_LAST);

    // Next-state, qualification counter and arrival pulse
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        veh_pulse  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (loop_s) state_next = QUAL_ON;
            end
            QUAL_ON: begin
                if (!loop_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_done) begin
                    state_next = PRESENT;
                    cnt_next   = '0;
                    veh_pulse  = 1'b1;
                end
            end
            PRESENT: begin
                cnt_next = '0;
                if (!loop_s) state_next = QUAL_OFF;
            end
            QUAL_OFF: begin
                if (loop_s) begin
                    state_next = PRESENT;
                    cnt_next   = '0;
                end else if (cnt_done) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign loop_db = (state == PRESENT) || (state == QUAL_OFF);

endmodule

// File: rtl/sen_loop_detector.sv
// Side-street sensor request generator for ej_maq_est.
// Debounced vehicle arrivals increment a saturating pending count; each full
// run of SERVE_CYCLES green cycles discharges one vehicle. 'sen' is held while
// vehicles remain pending.
// Optional feature: define SEN_STUCK_DET_EN to enable the stuck-loop detector.
module sen_loop_detector
    import sen_det_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned SERVE_CYCLES = 8,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned STUCK_CYCLES = 64
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_raw,
    input  logic [2:0]       St,
    output logic             sen,
    output logic [CNT_W-1:0] pending,
    output logic             veh_pulse,
    output logic             stuck
);

    localparam int unsigned      SW         = cnt_width(SERVE_CYCLES);
    localparam logic [SW-1:0]    SERVE_LAST = SW'(SERVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEND_MAX   = '1;

    logic             loop_db;
    state_t           db_state;
    logic [SW-1:0]    serve_tmr;
    logic             green;
    logic             serve_wrap;
    logic [CNT_W-1:0] pending_next;
    logic             sen_next;
    logic             unused_sig;

    loop_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .loop_raw  (loop_raw),
        .loop_db   (loop_db),
        .veh_pulse (veh_pulse),
        .state     (db_state)
    );

    // Any light other than pure green (illegal codes included) is "not served"
    assign green      = (St == LIGHT_GRN);
    assign serve_wrap = green && (serve_tmr == SERVE_LAST);

    // Serve timer: credits consecutive green cycles, partial runs are discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             serve_tmr <= '0;
        else if (!green)     serve_tmr <= '0;
        else if (serve_wrap) serve_tmr <= '0;
        else                 serve_tmr <= serve_tmr + 1'b1;
    end

    // Pending count update: arrival and discharge in the same cycle cancel out
    always_comb begin
        pending_next = pending;
        case ({veh_pulse, serve_wrap})
            2'b10:   if (pending != PEND_MAX) pending_next = pending + 1'b1;
            2'b01:   if (pending != '0)       pending_next = pending - 1'b1;
            default: pending_next = pending;
        endcase
    end

    // Pending counter and registered request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            sen     <= 1'b0;
        end else begin
            pending <= pending_next;
            sen     <= sen_next;
        end
    end

`ifdef SEN_STUCK_DET_EN
    localparam int unsigned   KW         = cnt_width(STUCK_CYCLES);
    localparam logic [KW-1:0] STUCK_LAST = KW'(STUCK_CYCLES - 1);

    logic [KW-1:0] stuck_tmr;
    logic          stuck_hit;
    logic          stuck_next;

    assign stuck_hit = (db_state == PRESENT) && (stuck_tmr == STUCK_LAST);

    // Stuck timer: time spent continuously in PRESENT, holds once expired
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      stuck_tmr <= '0;
        else if (db_state != PRESENT) stuck_tmr <= '0;
        else if (!stuck_hit)          stuck_tmr <= stuck_tmr + 1'b1;
    end

    // Fault flag: sets on expiry, clears only once the loop has fully released
    always_comb begin
        stuck_next = stuck;
        if (db_state == IDLE) stuck_next = 1'b0;
        else if (stuck_hit)   stuck_next = 1'b1;
    end

    // Stuck flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stuck <= 1'b0;
        else     stuck <= stuck_next;
    end

    // A stuck loop keeps the request up so the side street keeps being served
    assign sen_next   = (pending_next != '0) | stuck_next;
    assign unused_sig = loop_db;
`else
    assign stuck      = 1'b0;
    assign sen_next   = (pending_next != '0);
    assign unused_sig = ^{loop_db, db_state, STUCK_CYCLES[0]};
`endif

endmodule
